alu_divider_rv32im: RTL and testbench
=====================================

# alu_divider_rv32im

Iterative restoring divider for the RV32IM M-extension ops DIV, DIVU, REM and REMU. It sits beside the combinational ALU comparator in the execute stage. Each iteration performs one subtract-and-compare step, turning the comparator's magnitude decision into one quotient bit. Operands enter and results leave through valid/ready handshakes, so the pipeline stalls while the divider is busy.

## Interface
- data_width, 32: operand/result width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  divider can accept; high only in IDLE with kill low.
- op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- operand_A  in  data_width  dividend.
- operand_B  in  data_width  divisor.
- kill  in  1  pipeline flush; abandons any operation.
- out_valid  out  1  result is valid; high only in DONE.
- out_ready  in  1  consumer takes the result.
- result  out  data_width  quotient (DIV/DIVU) or remainder (REM/REMU).
- busy  out  1  high in CALC, FIX and DONE.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE -> CALC on in_valid && in_ready.
  - Latch op.
  - Latch |A| and |B| for signed ops, raw values for unsigned ops.
  - Latch quotient-negate flag (sign A xor sign B) and remainder-negate flag (sign A); both are 0 for unsigned ops.
  - Latch special-case flags: div_by_zero (B==0) and overflow (signed op, A==0x80000000, B==0xFFFFFFFF).
  - Clear the 32-bit partial remainder and set iteration counter to 31.
- CALC, one bit per cycle:
  - Form trial = {rem[30:0], dividend[31]} - divisor in 33-bit arithmetic.
  - If trial is non-negative: rem <= trial, and the quotient bit shifted in is 1.
  - Otherwise: rem <= the shifted value, and the quotient bit shifted in is 0.
  - The dividend register shifts left each cycle; quotient bits fill it from the LSB.
  - When counter == 0, go to FIX; otherwise decrement the counter.
- FIX: apply sign correction, then mux in special cases, register result, go to DONE.
  - div_by_zero: quotient = 0xFFFFFFFF, remainder = original A.
  - overflow: quotient = 0x80000000, remainder = 0.
- DONE: hold result and out_valid. Go to IDLE on out_ready.
- kill, from any state: next state is IDLE, out_valid drops, and the result is discarded.
  - kill wins over a simultaneous in_valid; in_ready is low that cycle.
- Reset values: state IDLE; in_ready 1; out_valid 0; busy 0; result 0; all internal registers 0.
- Reset asserted mid-operation returns immediately to IDLE. No result is produced.

## Timing
- Accepting edge is E. CALC occupies 32 cycles and FIX occupies 1 cycle.
- out_valid is high from edge E+34.
- out_ready held high gives the earliest next acceptance at edge E+35. There is no back-to-back overlap.
- result is stable while out_valid is high and out_ready is low.
- in_ready is combinational from state and kill. No other output depends combinationally on an input.

## Configuration
- ALU_DIV_FAST_SPECIAL_EN defined: if div_by_zero or overflow is detected at acceptance, go IDLE -> DONE directly.
  - The special-case result is registered at edge E, and out_valid is high from E+1.
- Undefined: special cases run the full CALC/FIX sequence. Results are identical; latency is 34 cycles.

## Structure
- Package alu_rv32im_pkg holds:
  - div_op_t enum (DIV, DIVU, REM, REMU).
  - div_state_t enum.
  - Constants DIV_ITERATIONS = 32 and INT_MIN = 32'h8000_0000.
- One sub-module, alu_div_step: combinational 33-bit trial subtract. It returns the next remainder and the quotient bit.

## Test plan
- DIVU 100 / 7: result 14 at E+34. REMU 100 / 7: result 2.
- DIV -7 / 2 -> 0xFFFFFFFD (-3). REM -7 / 2 -> 0xFFFFFFFF (-1).
- DIV 5 / 0 -> 0xFFFFFFFF. REM 5 / 0 -> 5. Latency is E+34 without the macro, E+1 with it.
- DIV 0x80000000 / -1 -> 0x80000000. REM of the same operands -> 0.
- Hold out_ready low 10 cycles in DONE: result is stable and in_ready is 0. Raising out_ready returns to IDLE.
- kill at CALC cycle 10, and separately with in_valid in IDLE: no out_valid, next op 9/3 -> 3.

Source files
------------

// File: rtl/alu_rv32im_pkg.sv
// alu_rv32im_pkg: shared types, constants and special-case result helper for the RV32IM divider
package alu_rv32im_pkg;
  typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_t;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
  localparam int DIV_ITERATIONS = 32;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  function automatic logic [31:0] special_result(input logic rem_op, input logic dbz, input logic [31:0] a);
    return dbz ? (rem_op ? a : 32'hFFFF_FFFF) : (rem_op ? 32'h0 : INT_MIN);
  endfunction
endpackage

// File: rtl/alu_div_step.sv
// alu_div_step: one restoring-division step (33-bit trial subtract of the divisor from the shifted remainder)
// Ports: rem/msb form the shifted partial remainder, divisor is the magnitude divisor;
// next_rem is the updated remainder and q_bit the quotient bit produced this step.
module alu_div_step (
  input  logic [31:0] rem,
  input  logic        msb,
  input  logic [31:0] divisor,
  output logic [31:0] next_rem,
  output logic        q_bit
);
  logic [32:0] trial;
  // rem[31] is always clear before the final step, so dropping it loses nothing
  assign trial    = {1'b0, rem[30:0], msb} - {1'b0, divisor};
  assign q_bit    = ~trial[32];
  assign next_rem = q_bit ? trial[31:0] : {rem[30:0], msb};
endmodule

// File: rtl/alu_divider_rv32im.sv
// alu_divider_rv32im: iterative restoring divider for RV32IM DIV/DIVU/REM/REMU with valid/ready handshakes
// Ports: clk, rst_n (async active-low); in_valid/in_ready/op/operand_A/operand_B accept an operation;
// kill flushes; out_valid/out_ready/result return it; busy is high while an operation is in flight.
// Define ALU_DIV_FAST_SPECIAL_EN to retire divide-by-zero and overflow directly from IDLE to DONE.
module alu_divider_rv32im
  import alu_rv32im_pkg::*;
#(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [data_width-1:0] operand_A,
  input  logic [data_width-1:0] operand_B,
  input  logic                  kill,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] result,
  output logic                  busy
);
  div_state_t  state;
  div_op_t     op_q;
  logic [31:0] dividend, divisor, rem, a_q, next_rem, q_fix, r_fix, fix_res;
  logic [4:0]  cnt;
  logic        neg_q, neg_r, dbz, ovf, q_bit, is_rem;
  logic        signed_op, sign_a, sign_b, dbz_in, ovf_in;
  assign signed_op = (op == DIV) || (op == REM);
  assign sign_a    = signed_op & operand_A[31];
  assign sign_b    = signed_op & operand_B[31];
  assign dbz_in    = operand_B == 32'h0;
  assign ovf_in    = signed_op && operand_A == INT_MIN && operand_B == 32'hFFFF_FFFF;
  assign is_rem    = (op_q == REM) || (op_q == REMU);
  assign q_fix     = neg_q ? -dividend : dividend;
  assign r_fix     = neg_r ? -rem : rem;
  assign fix_res   = (dbz || ovf) ? special_result(is_rem, dbz, a_q) : (is_rem ? r_fix : q_fix);
  assign in_ready  = (state == IDLE) && !kill;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  alu_div_step u_step (
    .rem      (rem),
    .msb      (dividend[31]),
    .divisor  (divisor),
    .next_rem (next_rem),
    .q_bit    (q_bit)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= DIV;
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      a_q      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dbz      <= 1'b0;
      ovf      <= 1'b0;
      result   <= '0;
    end else if (kill) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q     <= div_op_t'(op);
          dividend <= sign_a ? -operand_A : operand_A;
          divisor  <= sign_b ? -operand_B : operand_B;
          a_q      <= operand_A;
          neg_q    <= sign_a ^ sign_b;
          neg_r    <= sign_a;
          dbz      <= dbz_in;
          ovf      <= ovf_in;
          rem      <= '0;
          cnt      <= 5'(DIV_ITERATIONS - 1);
`ifdef ALU_DIV_FAST_SPECIAL_EN
          if (dbz_in || ovf_in) begin
            result <= special_result(op[1], dbz_in, operand_A);
            state  <= DONE;
          end else begin
            state <= CALC;
          end
`else
          state <= CALC;
`endif
        end
        CALC: begin
          dividend <= {dividend[30:0], q_bit};
          rem      <= next_rem;
          cnt      <= cnt - 5'd1;
          if (cnt == 5'd0) state <= FIX;
        end
        FIX: begin
          result <= fix_res;
          state  <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_divider_rv32im.sv
// tb_alu_divider_rv32im: directed self-checking bench for alu_divider_rv32im
module tb_alu_divider_rv32im;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
`ifdef ALU_DIV_FAST_SPECIAL_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 34;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, kill = 1'b0, out_ready = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;
  int passed = 0, total = 0;
  alu_divider_rv32im dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand_A (operand_a),
    .operand_B (operand_b),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  task automatic start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  // lat is the edge index after acceptance at which out_valid is first visible to the consumer
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int lat);
    start(o, a, b);
    r = 'x;
    for (lat = 1; lat <= 100; lat++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    if (lat > 100) lat = 999;
    r = result;
  endtask
  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask
  task automatic test_reset();
    total += 4;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    if (result !== 32'h0) $display("FAIL reset_result: got %h expected 0", result); else passed++;
  endtask
  task automatic test_unsigned();
    logic [31:0] r;
    int lat;
    issue(OP_DIVU, 32'd100, 32'd7, r, lat); retire();
    total += 2;
    if (r !== 32'd14) $display("FAIL divu_100_7: got %h expected %h", r, 32'd14); else passed++;
    if (lat !== 34) $display("FAIL divu_latency: got %0d expected 34", lat); else passed++;
    issue(OP_REMU, 32'd100, 32'd7, r, lat); retire();
    total++;
    if (r !== 32'd2) $display("FAIL remu_100_7: got %h expected %h", r, 32'd2); else passed++;
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, r, lat); retire();
    total++;
    if (r !== 32'd1) $display("FAIL divu_large: got %h expected %h", r, 32'd1); else passed++;
    issue(OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, r, lat); retire();
    total++;
    if (r !== 32'h7FFF_FFFE) $display("FAIL remu_large: got %h expected 7ffffffe", r); else passed++;
  endtask
  task automatic test_signed();
    logic [31:0] r;
    int lat;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, r, lat); retire();
    total++;
    if (r !== 32'hFFFF_FFFD) $display("FAIL div_m7_2: got %h expected fffffffd", r); else passed++;
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, r, lat); retire();
    total++;
    if (r !== 32'hFFFF_FFFF) $display("FAIL rem_m7_2: got %h expected ffffffff", r); else passed++;
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, r, lat); retire();
    total++;
    if (r !== 32'hFFFF_FFFD) $display("FAIL div_7_m2: got %h expected fffffffd", r); else passed++;
    issue(OP_REM, 32'd7, 32'hFFFF_FFFE, r, lat); retire();
    total++;
    if (r !== 32'd1) $display("FAIL rem_7_m2: got %h expected 00000001", r); else passed++;
  endtask
  task automatic test_div_zero();
    logic [31:0] r;
    int lat;
    issue(OP_DIV, 32'd5, 32'd0, r, lat); retire();
    total += 2;
    if (r !== 32'hFFFF_FFFF) $display("FAIL div_by_zero: got %h expected ffffffff", r); else passed++;
    if (lat !== SPEC_LAT) $display("FAIL div_by_zero_latency: got %0d expected %0d", lat, SPEC_LAT); else passed++;
    issue(OP_REM, 32'd5, 32'd0, r, lat); retire();
    total += 2;
    if (r !== 32'd5) $display("FAIL rem_by_zero: got %h expected 00000005", r); else passed++;
    if (lat !== SPEC_LAT) $display("FAIL rem_by_zero_latency: got %0d expected %0d", lat, SPEC_LAT); else passed++;
    issue(OP_REMU, 32'hFFFF_FFF9, 32'd0, r, lat); retire();
    total++;
    if (r !== 32'hFFFF_FFF9) $display("FAIL remu_by_zero: got %h expected fffffff9", r); else passed++;
  endtask
  task automatic test_overflow();
    logic [31:0] r;
    int lat;
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, lat); retire();
    total += 2;
    if (r !== 32'h8000_0000) $display("FAIL div_overflow: got %h expected 80000000", r); else passed++;
    if (lat !== SPEC_LAT) $display("FAIL overflow_latency: got %0d expected %0d", lat, SPEC_LAT); else passed++;
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, lat); retire();
    total++;
    if (r !== 32'h0) $display("FAIL rem_overflow: got %h expected 00000000", r); else passed++;
  endtask
  task automatic test_hold();
    logic [31:0] r;
    int lat, bad_res, bad_rdy;
    bad_res = 0; bad_rdy = 0;
    issue(OP_DIVU, 32'd100, 32'd7, r, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (result !== 32'd14 || out_valid !== 1'b1) bad_res++;
      if (in_ready !== 1'b0) bad_rdy++;
    end
    total += 2;
    if (bad_res != 0) $display("FAIL hold_result: got %0d unstable cycles expected 0 (last %h)", bad_res, result); else passed++;
    if (bad_rdy != 0) $display("FAIL hold_in_ready: got %0d cycles with in_ready expected 0", bad_rdy); else passed++;
    retire();
    total += 2;
    if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b expected 1", in_ready); else passed++;
    if (out_valid !== 1'b0) $display("FAIL release_out_valid: got %b expected 0", out_valid); else passed++;
  endtask
  task automatic test_kill_calc();
    logic [31:0] r;
    int lat, seen;
    seen = 0;
    start(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    total++;
    if (busy !== 1'b0) $display("FAIL kill_calc_busy: got %b expected 0", busy); else passed++;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL kill_calc_out_valid: got %0d valid cycles expected 0", seen); else passed++;
    issue(OP_DIVU, 32'd9, 32'd3, r, lat); retire();
    total++;
    if (r !== 32'd3) $display("FAIL after_kill_calc: got %h expected 00000003", r); else passed++;
  endtask
  task automatic test_kill_idle();
    logic [31:0] r;
    int lat, seen;
    seen = 0;
    @(negedge clk);
    op = OP_DIVU; operand_a = 32'd100; operand_b = 32'd7; in_valid = 1'b1; kill = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) $display("FAIL kill_idle_in_ready: got %b expected 0", in_ready); else passed++;
    @(posedge clk);
    #1 in_valid = 1'b0; kill = 1'b0;
    total++;
    if (busy !== 1'b0) $display("FAIL kill_idle_busy: got %b expected 0", busy); else passed++;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL kill_idle_out_valid: got %0d valid cycles expected 0", seen); else passed++;
    issue(OP_DIV, 32'd9, 32'd3, r, lat); retire();
    total++;
    if (r !== 32'd3) $display("FAIL after_kill_idle: got %h expected 00000003", r); else passed++;
  endtask
  task automatic test_reset_mid();
    start(OP_DIVU, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total += 2;
    if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b expected 0", busy); else passed++;
    if (result !== 32'h0) $display("FAIL mid_reset_result: got %h expected 0", result); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL mid_reset_in_ready: got %b expected 1", in_ready); else passed++;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_hold();
    test_kill_calc();
    test_kill_idle();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
